// File: rtl/result_unloader.sv
// Result unloader: snapshots the product matrix on res_done and streams it out as nibbles.
// Latency: rows nibble is valid in the cycle after the res_done edge, then one nibble per transfer.
// Backpressure: valid/ready; dout/dout_last hold until dout_valid & dout_ready, and stalls cost no extra bubbles.
//
// Ports:
//   CLK, RST_N       clock (rising edge) and asynchronous active-low reset
//   res_flat         product matrix, element i at [i*DATA_W +: DATA_W], row-major
//   res_rows/cols    product dimensions
//   res_done         1-cycle pulse, res_* valid this cycle
//   dout/_valid/_ready/_last  nibble stream: header (rows, cols), then elements MSB nibble first
//   busy             high from capture until the frame is complete
//   unload_done      1-cycle pulse after the last nibble has been transferred
//   overrun          sticky, set when res_done arrives while busy
//   size_err         rows*cols exceeded MAX_ELEMS on the last capture
module result_unloader #(
    parameter int MAX_ELEMS = 8,
    parameter int DATA_W    = 32,
    parameter int NIB_W     = 4,
    parameter int DIM_W     = 4
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [MAX_ELEMS*DATA_W-1:0]   res_flat,
    input  logic [DIM_W-1:0]              res_rows,
    input  logic [DIM_W-1:0]              res_cols,
    input  logic                          res_done,
    output logic [NIB_W-1:0]              dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          dout_last,
    output logic                          busy,
    output logic                          unload_done,
    output logic                          overrun,
    output logic                          size_err
);

    localparam int NPE = DATA_W / NIB_W;                      // nibbles per element
    localparam int K_W = (NPE > 1) ? $clog2(NPE) : 1;
    localparam int E_W = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
    localparam int N_W = 2 * DIM_W;
    localparam logic [K_W-1:0] K_LAST = K_W'(NPE - 1);
    localparam logic [N_W-1:0] MAX_N  = N_W'(MAX_ELEMS);

    typedef enum logic [2:0] {
        IDLE,
        HDR_R,
        HDR_C,
        DATA,
        FIN
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [MAX_ELEMS];
    logic [DIM_W-1:0]  rows_q, cols_q;
    logic              skip_data;      // frame is header-only (n==0 or oversize)
    logic [E_W-1:0]    e_last;         // index of final element, meaningful only when !skip_data
    logic [E_W-1:0]    e_idx;
    logic [K_W-1:0]    k_idx;
    logic [N_W-1:0]    n_in;
    logic              capture;
    logic              xfer;
    logic              at_last;
    logic [DATA_W-1:0] elem_sh;

    // Full-width product so an oversize request is never aliased into range.
    assign n_in    = N_W'(res_rows) * N_W'(res_cols);
    assign capture = res_done && (state == IDLE);
    assign xfer    = dout_valid && dout_ready;
    assign at_last = (e_idx == e_last) && (k_idx == K_LAST);
    // Shift the current nibble up to the MSB position so the slice below is constant.
    assign elem_sh = mem[e_idx] << (32'(k_idx) * NIB_W);
    assign busy    = (state != IDLE);

    // Snapshot buffer: contents are don't-care out of reset, so no reset here.
    always_ff @(posedge CLK) begin
        if (capture) begin
            for (int i = 0; i < MAX_ELEMS; i++) begin
                mem[i] <= res_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rows_q    <= '0;
            cols_q    <= '0;
            skip_data <= 1'b0;
            e_last    <= '0;
            e_idx     <= '0;
            k_idx     <= '0;
            size_err  <= 1'b0;
            overrun   <= 1'b0;
        end else if (capture) begin
            rows_q    <= res_rows;
            cols_q    <= res_cols;
            skip_data <= (n_in == '0) || (n_in > MAX_N);
            e_last    <= E_W'(n_in - N_W'(1));
            e_idx     <= '0;
            k_idx     <= '0;
            size_err  <= (n_in > MAX_N);
            overrun   <= 1'b0;
        end else begin
            // Any res_done outside IDLE (HDR_R..FIN) is dropped and flagged.
            if (res_done) begin
                overrun <= 1'b1;
            end
            if ((state == DATA) && xfer) begin
                if (k_idx == K_LAST) begin
                    k_idx <= '0;
                    e_idx <= e_idx + E_W'(1);
                end else begin
                    k_idx <= k_idx + K_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        dout        = '0;
        dout_valid  = 1'b0;
        dout_last   = 1'b0;
        unload_done = 1'b0;
        case (state)
            IDLE: begin
                if (res_done) begin
                    state_nxt = HDR_R;
                end
            end
            HDR_R: begin
                dout       = NIB_W'(rows_q);
                dout_valid = 1'b1;
                if (xfer) begin
                    state_nxt = HDR_C;
                end
            end
            HDR_C: begin
                dout       = NIB_W'(cols_q);
                dout_valid = 1'b1;
                dout_last  = skip_data;
                if (xfer) begin
                    state_nxt = skip_data ? FIN : DATA;
                end
            end
            DATA: begin
                dout       = elem_sh[DATA_W-1 -: NIB_W];
                dout_valid = 1'b1;
                dout_last  = at_last;
                if (xfer && at_last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                unload_done = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_unloader.sv
// Bench for result_unloader: scoreboard of expected {last, nibble} words, filled when a frame is launched
// and drained on every observed transfer. Outputs are sampled on the falling edge; inputs change 1ns after
// the rising edge.
module tb_result_unloader;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [255:0] res_flat = '0;
    logic [3:0]   res_rows = '0;
    logic [3:0]   res_cols = '0;
    logic         res_done = 1'b0;
    logic [3:0]   dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic         dout_last;
    logic         busy;
    logic         unload_done;
    logic         overrun;
    logic         size_err;

    result_unloader dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .res_flat    (res_flat),
        .res_rows    (res_rows),
        .res_cols    (res_cols),
        .res_done    (res_done),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .busy        (busy),
        .unload_done (unload_done),
        .overrun     (overrun),
        .size_err    (size_err)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [4:0]  sb[$];
    logic [31:0] stim [8];
    int          xfers = 0, vld_cyc = 0, stall_cyc = 0, done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [4:0]  prev_dat = '0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_vld", 32'(dout_valid), 32'd1);
                chk("hold_dat", 32'({dout_last, dout}), 32'(prev_dat));
            end
            if (unload_done) done_cnt++;
            if (dout_valid) begin
                vld_cyc++;
                if (!dout_ready) stall_cyc++;
            end
            if (dout_valid && dout_ready) begin
                xfers++;
                if (sb.size() == 0) chk("extra_nib", 32'({dout_last, dout}), 32'hffff_ffff);
                else                chk("nib", 32'({dout_last, dout}), 32'(sb.pop_front()));
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dat   = {dout_last, dout};
        end
    end

    // ready pattern: 0 = always ready, 1 = toggling, 2 = random
    int mode = 0;
    always @(posedge CLK) begin
        #1;
        case (mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ~dout_ready;
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- stimulus helpers ----------------
    function automatic int frame_len(input int r, input int c);
        int n = r * c;
        return (n == 0 || n > 8) ? 2 : 2 + n * 8;
    endfunction

    task automatic push_frame(input logic [3:0] r, input logic [3:0] c);
        int  n = int'(r) * int'(c);
        bit  sk = (n == 0) || (n > 8);
        logic [31:0] w;
        sb.push_back({1'b0, r});
        sb.push_back({sk, c});
        if (!sk) begin
            for (int e = 0; e < n; e++) begin
                w = stim[e];
                for (int k = 0; k < 8; k++) begin
                    sb.push_back({(e == n - 1) && (k == 7), w[31:28]});
                    w = w << 4;
                end
            end
        end
    endtask

    // Pulse res_done for one cycle; when check_lat is set, the rows nibble must be presented right away.
    task automatic pulse(input logic [3:0] r, input logic [3:0] c, input bit check_lat);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 8; i++) res_flat[i*32 +: 32] = stim[i];
        res_rows = r;
        res_cols = c;
        res_done = 1'b1;
        @(posedge CLK);
        #1;
        res_done = 1'b0;
        if (check_lat) begin
            chk("lat_vld", 32'(dout_valid), 32'd1);
            chk("lat_hdr", 32'({dout_last, dout}), 32'({1'b0, r}));
            chk("busy_start", 32'(busy), 32'd1);
        end
    endtask

    task automatic start_frame(input logic [3:0] r, input logic [3:0] c);
        push_frame(r, c);
        xfers = 0;
        vld_cyc = 0;
        stall_cyc = 0;
        pulse(r, c, 1'b1);
    endtask

    task automatic wait_done(input int exp_len);
        int  t = 0;
        bit  seen = 1'b0;
        while (!seen && t < 3000) begin
            @(posedge CLK);
            #2;
            t++;
            seen = unload_done;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("fin_vld", 32'(dout_valid), 32'd0);
        chk("len", 32'(xfers), 32'(exp_len));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("cycles", 32'(vld_cyc), 32'(exp_len + stall_cyc));
        @(posedge CLK);
        #2;
        chk("done_1cyc", 32'(unload_done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    int d0;

    initial begin
        stim = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'hFFFF_FFFF,
                 32'h0, 32'h0, 32'h0, 32'h0};
        #1;
        chk("rst_vld",  32'(dout_valid), 32'd0);
        chk("rst_dout", 32'({dout_last, dout}), 32'd0);
        chk("rst_flags", 32'({busy, unload_done, overrun, size_err}), 32'd0);
        #12 RST_N = 1'b1;
        repeat (2) @(posedge CLK);

        // 1: 2x2 frame, always ready
        mode = 0;
        start_frame(4'd2, 4'd2);
        wait_done(frame_len(2, 2));

        // 2: same frame under toggling and random backpressure
        mode = 1;
        start_frame(4'd2, 4'd2);
        wait_done(frame_len(2, 2));
        mode = 2;
        start_frame(4'd2, 4'd2);
        wait_done(frame_len(2, 2));
        chk("stalls_seen", 32'(stall_cyc > 0), 32'd1);
        mode = 0;

        // 3: empty product
        start_frame(4'd0, 4'd3);
        chk("szerr_0x3", 32'(size_err), 32'd0);
        wait_done(frame_len(0, 3));

        // 4: oversize product, then a 1x1 capture clears the flag
        start_frame(4'd3, 4'd3);
        chk("szerr_3x3", 32'(size_err), 32'd1);
        wait_done(frame_len(3, 3));
        chk("szerr_sticky", 32'(size_err), 32'd1);
        stim[0] = 32'hCAFE_0001;
        start_frame(4'd1, 4'd1);
        chk("szerr_clr", 32'(size_err), 32'd0);
        wait_done(frame_len(1, 1));

        // 5: res_done during DATA is ignored and flagged
        stim[0] = 32'h0123_4567;
        stim[1] = 32'h89AB_CDEF;
        start_frame(4'd1, 4'd2);
        repeat (5) @(posedge CLK);
        stim[0] = 32'hDEAD_BEEF;
        stim[1] = 32'h5555_AAAA;
        pulse(4'd2, 4'd1, 1'b0);
        chk("ovr_set", 32'(overrun), 32'd1);
        wait_done(frame_len(1, 2));
        chk("ovr_sticky", 32'(overrun), 32'd1);
        stim[0] = 32'h7;
        start_frame(4'd1, 4'd1);
        chk("ovr_clr", 32'(overrun), 32'd0);
        wait_done(frame_len(1, 1));

        // 6: asynchronous reset mid-DATA abandons the frame
        stim = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'hFFFF_FFFF,
                 32'h0, 32'h0, 32'h0, 32'h0};
        start_frame(4'd2, 4'd2);
        repeat (8) @(posedge CLK);
        d0 = done_cnt;
        #3 RST_N = 1'b0;
        #1;
        chk("arst_vld", 32'(dout_valid), 32'd0);
        chk("arst_dout", 32'({dout_last, dout}), 32'd0);
        chk("arst_flags", 32'({busy, unload_done, overrun, size_err}), 32'd0);
        @(posedge CLK);
        #3 RST_N = 1'b1;
        sb.delete();
        repeat (4) @(posedge CLK);
        #2;
        chk("arst_no_done", 32'(done_cnt), 32'(d0));
        chk("arst_idle", 32'(busy), 32'd0);
        stim[0] = 32'hA5A5_5A5A;
        start_frame(4'd1, 4'd1);
        wait_done(frame_len(1, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends with a summary.
    initial begin
        #500000;
        chk("watchdog", 32'd1, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
